// File: rtl/pipe_cla_addsub.sv
// Pipelined WIDTH-bit add/subtract built from 4-bit carry-lookahead groups, GROUPS_PER_STAGE
// groups resolved per stage. Define ADDSUB_SAT_EN to add per-beat signed saturation.
module pipe_cla_addsub #(
  parameter int WIDTH            = 32,
  parameter int GROUPS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int G      = GROUPS_PER_STAGE;
  localparam int SW     = 4 * G;
  localparam int STAGES = WIDTH / SW;

  if (WIDTH < SW || (WIDTH % SW) != 0) begin : g_bad_cfg
    $error("pipe_cla_addsub: WIDTH must be a positive multiple of 4*GROUPS_PER_STAGE");
  end

  // Returns {carry into slice MSB, carry out of slice, slice sum} for SW bits.
  function automatic logic [SW+1:0] cla_slice(input logic [SW-1:0] x,
                                              input logic [SW-1:0] y,
                                              input logic          ci);
    logic [SW-1:0] p, g, s;
    logic          c, c1, c2, c3, gg, pp;
    p  = x ^ y;
    g  = x & y;
    s  = '0;
    c  = ci;
    c1 = 1'b0;
    c2 = 1'b0;
    c3 = 1'b0;
    gg = 1'b0;
    pp = 1'b0;
    for (int j = 0; j < G; j++) begin
      c1 = g[4*j] | (p[4*j] & c);
      c2 = g[4*j+1] | (p[4*j+1] & g[4*j]) | (&p[4*j +: 2] & c);
      c3 = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (&p[4*j+1 +: 2] & g[4*j]) | (&p[4*j +: 3] & c);
      gg = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (&p[4*j+2 +: 2] & g[4*j+1])
         | (&p[4*j+1 +: 3] & g[4*j]);
      pp = &p[4*j +: 4];
      s[4*j +: 4] = p[4*j +: 4] ^ {c3, c2, c1, c};
      c = gg | (pp & c);
    end
    return {c3, c, s};
  endfunction

  // Handshake: a beat moves in on in_valid & in_ready, a result leaves on out_valid & out_ready.
  // The whole pipeline advances together when out_ready | ~out_valid; otherwise every rank,
  // bubbles included, holds, so in_ready drops and the presented result stays stable.
  logic                         advance;
  logic [STAGES-1:0]            v_q, c_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q, bp_q, s_q;
  logic [STAGES-1:0][SW+1:0]    res;
  logic                         out_valid_q, cout_q, ovf_q, zero_q;
  logic [WIDTH-1:0]             sum_q, sum_d;
  logic                         cout_d, ovf_d, zero_d;
  logic                         unused_bits;

  assign advance  = out_ready | ~out_valid_q;
  assign in_ready = advance;

  // Rank k holds a beat whose low k slices are already resolved; stage k resolves slice k.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign res[k] = cla_slice(a_q[k][SW*k +: SW], bp_q[k][SW*k +: SW], c_q[k]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q         <= '0;
      c_q         <= '0;
      a_q         <= '0;
      bp_q        <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (advance) begin
      v_q[0]  <= in_valid;
      a_q[0]  <= a;
      bp_q[0] <= b ^ {WIDTH{sub}};
      c_q[0]  <= sub | cin;
      s_q[0]  <= '0;
      for (int k = 1; k < STAGES; k++) begin
        v_q[k]                  <= v_q[k-1];
        a_q[k]                  <= a_q[k-1];
        bp_q[k]                 <= bp_q[k-1];
        c_q[k]                  <= res[k-1][SW];
        s_q[k]                  <= s_q[k-1];
        s_q[k][SW*(k-1) +: SW]  <= res[k-1][SW-1:0];
      end
      out_valid_q <= v_q[STAGES-1];
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

`ifdef ADDSUB_SAT_EN
  logic [STAGES-1:0] sat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_q <= '0;
    end else if (advance) begin
      sat_q[0] <= sat;
      for (int k = 1; k < STAGES; k++) sat_q[k] <= sat_q[k-1];
    end
  end
`endif

  always_comb begin
    sum_d                = s_q[STAGES-1];
    sum_d[WIDTH-1 -: SW] = res[STAGES-1][SW-1:0];
    cout_d               = res[STAGES-1][SW];
    ovf_d                = res[STAGES-1][SW+1] ^ res[STAGES-1][SW];
`ifdef ADDSUB_SAT_EN
    if (sat_q[STAGES-1] && ovf_d)
      sum_d = a_q[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    zero_d = (sum_d == '0);
  end

  // Last-rank operand bits below the final slice and the unresolved top of s_q are dead.
`ifdef ADDSUB_SAT_EN
  assign unused_bits = ^{a_q[STAGES-1], bp_q[STAGES-1], s_q[STAGES-1], res};
`else
  assign unused_bits = ^{a_q[STAGES-1], bp_q[STAGES-1], s_q[STAGES-1], res, sat};
`endif

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: doc/pipe_cla_addsub.md
Name: pipe_cla_addsub

Overview:
- Parametrised, pipelined successor to the team's 4-bit carry-lookahead group adder, for the CPU datapath ALU.
- Splits a WIDTH-bit add/subtract into 4-bit CLA groups. Each group produces propagate/generate terms; groups are chained through registered carries, GROUPS_PER_STAGE groups per pipeline stage.
- Valid/ready handshake on both sides. Supports a whole-pipeline stall and fully pipelined throughput of one operation per cycle.

Parameters:
- WIDTH, 32: operand width in bits. Must be a multiple of 4*GROUPS_PER_STAGE; otherwise elaboration error.
- GROUPS_PER_STAGE, 2: number of 4-bit CLA groups resolved per pipeline stage.
- STAGES (derived, localparam), WIDTH/(4*GROUPS_PER_STAGE): pipeline depth and latency in cycles.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0: A+B+cin; 1: A+~B+1 (cin ignored)
- cin  in  1  carry-in for add
- sat  in  1  saturation request (used only with ADDSUB_SAT_EN)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB
- ovf  out  1  signed overflow
- zero  out  1  sum == 0

Behaviour:
- Reset: asynchronous on rst high. All valid bits clear; sum, cout, ovf, zero, and all stage data registers clear to 0. in_ready is 1 immediately after reset.
- Reset asserted mid-operation discards every in-flight beat; no partial result is ever presented.
- Advance: advance = out_ready | ~out_valid. in_ready = advance. A beat is accepted when in_valid & in_ready.
- When advance = 0, every stage register holds its value, including bubbles. The pipeline is stalled as a whole; there is no bubble collapsing.
- Stage k (0..STAGES-1) resolves bit range [4*G*k +: 4*G], where G = GROUPS_PER_STAGE.
- Within a stage, groups are chained by group carry c_next = gg | (pp & c_in). pp = AND of bit propagates (a^b'); gg = lookahead generate, as in the 4-bit group.
- b' = b ^ {WIDTH{sub}}. Carry into stage 0 is sub ? 1 : cin.
- Skew: unprocessed upper operand bits travel down the pipeline with the beat. Already-resolved low sum bits are also carried forward. The stage carry is registered between stages.
- Latency: a beat accepted on edge n appears with out_valid=1 after edge n+STAGES if no stall occurs. Throughput is 1 beat/cycle.
- Results leave in acceptance order. With out_valid=1 and out_ready=0, sum, cout, ovf, and zero hold stable.
- cout = carry out of bit WIDTH-1. For sub, cout=1 means no borrow (A >= B unsigned).
- ovf = carry into MSB XOR carry out of MSB.
- zero is computed in the last stage from the final sum (after saturation, if saturation is enabled).
- Simultaneous accept and emit in the same cycle is legal and required for full throughput.
- Outputs are undriven by beats only when out_valid=0. Their values are then don't-care, but they must not be X after reset.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined: when a beat has sat=1 and ovf=1, sum is replaced by 0x7FFF..F if operand A's sign is 0, or 0x8000..0 if it is 1. ovf still reports 1 and cout is unchanged. sat is carried down the pipeline with the beat.
- Undefined: the sat input is ignored and no saturation logic is synthesised.

Test Plan (WIDTH=32, GROUPS_PER_STAGE=2, latency 4):
- Reset then a single beat: a=0x0000_0008, b=0x0000_0001, cin=1, sub=0. Expect sum=0x0000_000A, cout=0, ovf=0, zero=0, out_valid high exactly 4 cycles after acceptance.
- Full-width carry ripple through all stages: a=0xFFFF_FFFF, b=0x0000_0001, cin=0 -> sum=0, cout=1, zero=1, ovf=0.
- Subtract and overflow:
  - a=0x8000_0000, b=0x0000_0001, sub=1 -> sum=0x7FFF_FFFF, ovf=1, cout=1.
  - a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, cout=0.
- Back-to-back: 8 consecutive beats with in_valid=1 and out_ready=1 -> 8 results on consecutive cycles, in order.
- Backpressure: hold out_ready=0 for 3 cycles while the pipeline is full -> in_ready=0, and sum/out_valid stable. On release, there is no loss or duplication.
- rst pulse while 3 beats are in flight -> out_valid=0 asynchronously; no stale results after release. With ADDSUB_SAT_EN: a=0x7FFF_FFFF, b=1, sat=1 -> sum=0x7FFF_FFFF, ovf=1.
